imem_wb_loader: RTL and testbench
=================================

// Module: imem_wb_loader
// PURPOSE
//  Wishbone classic responder that owns SRAM port 0 (RW) of the 32x512 instruction memory.
//  The management SoC loads and reads back program words over Wishbone instead of the logic-analyser bus.
//  The core fetches independently on port 1.
//  Provides a core-hold control bit so the core stays in reset while the image is loaded.
// PARAMETERS
//  ADDR_BASE  32'h3000_0000  base of 4 KB decode window (adr[31:12] compare)
//  AW         9              SRAM word-address width (512 words)
//  READ_LAT   1              cycles from SRAM read strobe to valid sram_dout0_i (1..3)
// PORTS
//  wb_clk_i       in   1   sole clock, rising edge
//  wb_rst_ni      in   1   synchronous reset, active low
//  wbs_cyc_i      in   1   Wishbone cycle
//  wbs_stb_i      in   1   Wishbone strobe
//  wbs_we_i       in   1   1=write, 0=read
//  wbs_sel_i      in   4   byte selects
//  wbs_adr_i      in   32  byte address
//  wbs_dat_i      in   32  write data
//  wbs_ack_o      out  1   single-cycle acknowledge
//  wbs_dat_o      out  32  read data, valid with ack
//  sram_csb0_o    out  1   SRAM port-0 chip select, active low
//  sram_web0_o    out  1   SRAM port-0 write enable, active low
//  sram_wmask0_o  out  4   SRAM byte write mask
//  sram_addr0_o   out  AW  SRAM word address
//  sram_din0_o    out  32  SRAM write data
//  sram_dout0_i   in   32  SRAM read data
//  core_hold_o    out  1   1 = hold core in reset
// BEHAVIOUR
//  Map (offset from ADDR_BASE):
//   0x000-0x7FC  SRAM window, word = adr[10:2]
//   0x800        CTRL: bit0 = hold, R/W; other bits read 0
//   0x804        WCOUNT: [15:0] completed window writes, saturates at 16'hFFFF; any write clears it
//   Other offsets inside the 4 KB window: writes ignored, reads return 0, still acked.
//  hit = cyc & stb & (adr[31:12] == ADDR_BASE[31:12]). No hit means no ack.
//  Reset values (all registered outputs): ack=0, dat_o=0, csb0=1, web0=1, wmask=0, addr=0, din=0, core_hold=1, WCOUNT=0.
//  FSM states: IDLE, SWR, SRD, SWAIT, ACK.
//   IDLE:  on hit to SRAM window:
//          - we=1: next state SWR; register addr/din/wmask=sel.
//          - we=0: next state SRD; register addr.
//          On hit to a register or unmapped offset: perform the access and go to ACK.
//   SWR:   csb0=0, web0=0 for exactly 1 cycle; ack=1 in the same cycle; WCOUNT+1; next state ACK.
//   SRD:   csb0=0, web0=1 for 1 cycle; next state SWAIT.
//   SWAIT: wait READ_LAT cycles; on the last cycle capture sram_dout0_i into dat_o, ack=1; next state ACK.
//   ACK:   ack=0, csb0=1; next state IDLE. Guarantees at least one idle cycle between transactions.
//  Latency, hit to ack (cycle of hit = 0):
//   - window write: ack at cycle 1
//   - window read: ack at cycle 2+READ_LAT-1
//   - register access: ack at cycle 1
//  ack is never held for more than 1 cycle.
//  wmask=0 on a window write: SRAM strobe is still issued, WCOUNT still increments.
//  cyc dropped in SRD or SWAIT: abort to IDLE without ack. dat_o keeps its old value.
//  A write already strobed in SWR is not undone.
//  Address wrap: adr[11]=0 selects the SRAM and upper address bits are ignored, so 0x7FC+4 maps to CTRL (no wrap to word 0).
//  CTRL hold is only a register; clearing it releases the core on the next cycle. SRAM port-0 access remains legal while hold=0.
//  Reset asserted mid-transaction: all outputs take reset values on the next edge; no ack is issued.
// CONFIGURATION
//  IMEM_READBACK_EN defined: SRAM window reads proceed as above.
//  Undefined:
//   - SRAM window reads skip SRD/SWAIT, return 32'h0 and ack at cycle 1.
//   - csb0 stays 1 for reads.
//   - SRAM port 0 becomes write-only.
//   - Register reads are unaffected.
// TESTING
//  1. Reset released -> core_hold_o=1, csb0=1, ack=0, WCOUNT read = 0.
//  2. Write 0xDEADBEEF, sel=4'hF, to base+0x010 -> addr0=4, din0=0xDEADBEEF, wmask=4'hF,
//     csb0=web0=0 for 1 cycle, ack at cycle 1; WCOUNT=1.
//  3. With IMEM_READBACK_EN and READ_LAT=1: read base+0x010, model returns 0xDEADBEEF ->
//     ack at cycle 2 with dat_o=0xDEADBEEF. Without the macro: ack at cycle 1 with 0.
//  4. Write 512 words, then write CTRL=0 -> WCOUNT=512 and core_hold_o falls 1 cycle after the CTRL ack.
//  5. Read started, cyc dropped in SWAIT -> no ack, FSM back in IDLE; next write completes normally.
//  6. Access to adr=0x3000_1000 -> no ack. Access to base+0x900 -> ack, read data 0.
//     wb_rst_ni pulsed low during SRD -> no ack, all outputs at reset values.

Source files
------------

// File: rtl/imem_wb_loader.sv
// imem_wb_loader: Wishbone loader for instruction SRAM port 0 plus core-hold/write-count registers.
// Define IMEM_READBACK_EN to let window reads go to the SRAM; otherwise port 0 is write-only.
module imem_wb_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          AW        = 9,
  parameter int          READ_LAT  = 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          sram_csb0_o,
  output logic          sram_web0_o,
  output logic [3:0]    sram_wmask0_o,
  output logic [AW-1:0] sram_addr0_o,
  output logic [31:0]   sram_din0_o,
  input  logic [31:0]   sram_dout0_i,
  output logic          core_hold_o
);
  typedef enum logic [2:0] {IDLE, SWR, SRD, SWAIT, ACK} stateT;
  stateT state, nextState;
  logic ackQ, ackD, csbQ, csbD, webQ, webD, holdQ, holdD, holdOut;
  logic [3:0] wmaskQ, wmaskD;
  logic [AW-1:0] addrQ, addrD;
  logic [31:0] dinQ, dinD, datQ, datD;
  logic [15:0] wcount, wcountD;
  logic [1:0] waitCnt, waitD;
  logic hit, lastWait, unusedAdr;
  assign unusedAdr = ^wbs_adr_i[1:0];
  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == ADDR_BASE[31:12]);
  // Read data arrives during the final wait cycle, so it is forwarded with ack and also kept in datQ.
  assign lastWait = (state == SWAIT) && (waitCnt == 2'd0) && wbs_cyc_i;
  always_comb begin
    nextState = state;
    ackD = 1'b0;
    csbD = 1'b1;
    webD = 1'b1;
    addrD = addrQ;
    dinD = dinQ;
    wmaskD = wmaskQ;
    datD = datQ;
    holdD = holdQ;
    wcountD = wcount;
    waitD = waitCnt;
    case (state)
      IDLE:
        if (hit && !wbs_adr_i[11]) begin
          addrD = wbs_adr_i[AW+1:2];
          if (wbs_we_i) begin
            nextState = SWR;
            dinD = wbs_dat_i;
            wmaskD = wbs_sel_i;
            csbD = 1'b0;
            webD = 1'b0;
            ackD = 1'b1;
          end else begin
`ifdef IMEM_READBACK_EN
            nextState = SRD;
            csbD = 1'b0;
`else
            nextState = ACK;
            ackD = 1'b1;
            datD = '0;
`endif
          end
        end else if (hit) begin
          nextState = ACK;
          ackD = 1'b1;
          datD = '0;
          if (wbs_adr_i[10:2] == 9'd0) begin
            holdD = wbs_we_i ? wbs_dat_i[0] : holdQ;
            datD = wbs_we_i ? '0 : {31'd0, holdQ};
          end else if (wbs_adr_i[10:2] == 9'd1) begin
            wcountD = wbs_we_i ? '0 : wcount;
            datD = wbs_we_i ? '0 : {16'd0, wcount};
          end
        end
      SWR: begin
        nextState = ACK;
        wcountD = (wcount == 16'hFFFF) ? wcount : wcount + 16'd1;
      end
      SRD: begin
        nextState = wbs_cyc_i ? SWAIT : IDLE;
        waitD = 2'(READ_LAT - 1);
      end
      SWAIT: begin
        nextState = !wbs_cyc_i ? IDLE : (waitCnt == 2'd0) ? ACK : SWAIT;
        waitD = waitCnt - 2'd1;
        datD = lastWait ? sram_dout0_i : datQ;
      end
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
      ackQ <= 1'b0;
      csbQ <= 1'b1;
      webQ <= 1'b1;
      addrQ <= '0;
      dinQ <= '0;
      wmaskQ <= '0;
      datQ <= '0;
      holdQ <= 1'b1;
      holdOut <= 1'b1;
      wcount <= '0;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      ackQ <= ackD;
      csbQ <= csbD;
      webQ <= webD;
      addrQ <= addrD;
      dinQ <= dinD;
      wmaskQ <= wmaskD;
      datQ <= datD;
      holdQ <= holdD;
      holdOut <= holdQ;
      wcount <= wcountD;
      waitCnt <= waitD;
    end
  end
  assign wbs_ack_o = ackQ | lastWait;
  assign wbs_dat_o = lastWait ? sram_dout0_i : datQ;
  assign sram_csb0_o = csbQ;
  assign sram_web0_o = webQ;
  assign sram_wmask0_o = wmaskQ;
  assign sram_addr0_o = addrQ;
  assign sram_din0_o = dinQ;
  assign core_hold_o = holdOut;
endmodule

// File: tb/tb_imem_wb_loader.sv
// tb_imem_wb_loader: randomized directed bench for imem_wb_loader with a byte-masked SRAM model
// and a word-array reference of the expected memory image, write count and hold bit.
module tb_imem_wb_loader;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef IMEM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int RDLAT = RB ? 2 : 1;
  logic clk = 1'b0, rstN = 1'b0;
  logic cyc = 1'b0, stb = 1'b0, weI = 1'b0;
  logic [3:0] selI = '0;
  logic [31:0] adrI = '0, datI = '0;
  logic ack, csb, web, hold;
  logic [31:0] datO, din;
  logic [3:0] wmask;
  logic [8:0] addr;
  logic [31:0] sramDout = '0;
  logic [31:0] mem [512];
  logic [31:0] refMem [512];
  int nChecks = 0, nFail = 0;
  int wrStb = 0, rdStb = 0;
  logic [8:0] lastA = '0;
  logic [31:0] lastD = '0;
  logic [3:0] lastM = '0;
  logic holdAtAck, holdNext, ackAfter, sawAck;
  int lat, w0, r0, wcnt, idx;
  logic [31:0] rd, d, prev;
  logic [3:0] s;

  always #5 clk = ~clk;

  imem_wb_loader dut (
    .wb_clk_i(clk), .wb_rst_ni(rstN), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(weI),
    .wbs_sel_i(selI), .wbs_adr_i(adrI), .wbs_dat_i(datI), .wbs_ack_o(ack), .wbs_dat_o(datO),
    .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask), .sram_addr0_o(addr),
    .sram_din0_o(din), .sram_dout0_i(sramDout), .core_hold_o(hold)
  );

  // Synchronous SRAM: strobe sampled at the edge, read data valid one cycle later.
  always @(posedge clk) begin
    if (!csb && !web)
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
    if (!csb && web) sramDout <= mem[addr];
  end

  always @(negedge clk) begin
    if (!csb && !web) begin
      wrStb <= wrStb + 1;
      lastA <= addr;
      lastD <= din;
      lastM <= wmask;
    end
    if (!csb && web) rdStb <= rdStb + 1;
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Classic cycle starting just after an edge; ack cycle index counted from the hit cycle (0).
  task automatic wb(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                    output logic [31:0] rdv, output int latv);
    weI = we; adrI = adr; selI = sel; datI = dat; cyc = 1'b1; stb = 1'b1;
    latv = -1;
    rdv = 'x;
    for (int k = 0; k < 8 && latv < 0; k++) begin
      @(negedge clk);
      if (ack) begin
        latv = k;
        rdv = datO;
        holdAtAck = hold;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; weI = 1'b0;
    @(negedge clk);
    holdNext = hold;
    ackAfter = ack;
    @(posedge clk); #1;
  endtask

  task automatic wrChk(input string tag, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] r;
    int l;
    wb(1'b1, adr, sel, dat, r, l);
    chk({tag, "_lat"}, 32'(l), 32'd1);
    chk({tag, "_ack1"}, 32'(ackAfter), 32'd0);
  endtask

  task automatic rdChk(input string tag, input logic [31:0] adr, input logic [31:0] exp, input int expLat);
    logic [31:0] r;
    int l;
    wb(1'b0, adr, 4'hF, 32'h0, r, l);
    chk({tag, "_lat"}, 32'(l), 32'(expLat));
    chk({tag, "_dat"}, r, exp);
    chk({tag, "_ack1"}, 32'(ackAfter), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_csb_web", 32'({csb, web}), 32'd3);
    chk("rst_hold", 32'(hold), 32'd1);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_wmask", 32'(wmask), 32'd0);
    chk("rst_dat", datO, 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    rdChk("wcount_rst", BASE + 32'h804, 32'd0, 1);

    w0 = wrStb;
    wrChk("wr_dead", BASE + 32'h10, 4'hF, 32'hDEADBEEF);
    refMem[4] = 32'hDEADBEEF;
    wcnt = 1;
    chk("wr_strobes", 32'(wrStb - w0), 32'd1);
    chk("wr_addr", 32'(lastA), 32'd4);
    chk("wr_din", lastD, 32'hDEADBEEF);
    chk("wr_mask", 32'(lastM), 32'hF);
    rdChk("wcount_1", BASE + 32'h804, 32'(wcnt), 1);
    r0 = rdStb;
    rdChk("rd_dead", BASE + 32'h10, RB ? 32'hDEADBEEF : 32'h0, RDLAT);
    chk("rd_strobes", 32'(rdStb - r0), RB ? 32'd1 : 32'd0);

    wrChk("wcount_clr", BASE + 32'h804, 4'hF, $urandom);
    wcnt = 0;
    rdChk("wcount_clr_rd", BASE + 32'h804, 32'd0, 1);

    w0 = wrStb;
    for (int i = 0; i < 512; i++) begin
      d = $urandom;
      wrChk("fill", BASE + 32'(i * 4), 4'hF, d);
      refMem[i] = d;
      wcnt++;
    end
    chk("fill_strobes", 32'(wrStb - w0), 32'd512);
    rdChk("wcount_512", BASE + 32'h804, 32'(wcnt), 1);

    w0 = wrStb;
    for (int j = 0; j < 40; j++) begin
      idx = $urandom_range(0, 511);
      s = (j % 8 == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      d = $urandom;
      wrChk("pwr", BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), s, d);
      chk("pwr_addr", 32'(lastA), 32'(idx));
      chk("pwr_mask", 32'(lastM), 32'(s));
      refMem[idx] = merge(refMem[idx], d, s);
      wcnt++;
    end
    chk("pwr_strobes", 32'(wrStb - w0), 32'd40);
    rdChk("wcount_pwr", BASE + 32'h804, 32'(wcnt), 1);

    for (int j = 0; j < 24; j++) begin
      idx = (j == 0) ? 0 : (j == 1) ? 511 : $urandom_range(0, 511);
      rdChk("rdback", BASE + 32'(idx * 4), RB ? refMem[idx] : 32'h0, RDLAT);
    end

    w0 = wrStb;
    wrChk("wrap_ctrl", BASE + 32'h7FC + 32'h4, 4'hF, 32'h0);
    chk("wrap_no_strobe", 32'(wrStb - w0), 32'd0);
    chk("hold_at_ack", 32'(holdAtAck), 32'd1);
    chk("hold_after_ack", 32'(holdNext), 32'd0);
    rdChk("ctrl_rd0", BASE + 32'h800, 32'd0, 1);
    wrChk("ctrl_set", BASE + 32'h800, 4'hF, 32'hFFFF_FFFF);
    chk("hold_set", 32'(holdNext), 32'd1);
    rdChk("ctrl_rd1", BASE + 32'h800, 32'd1, 1);

    wb(1'b0, 32'h3000_1000, 4'hF, 32'h0, rd, lat);
    chk("miss_rd_noack", 32'(lat), 32'hFFFF_FFFF);
    wb(1'b1, 32'h2000_0010, 4'hF, 32'h1234, rd, lat);
    chk("miss_wr_noack", 32'(lat), 32'hFFFF_FFFF);
    rdChk("unmapped_rd", BASE + 32'h900, 32'd0, 1);
    w0 = wrStb;
    wrChk("unmapped_wr", BASE + 32'h900, 4'hF, 32'hFFFF_FFFF);
    chk("unmapped_no_strobe", 32'(wrStb - w0), 32'd0);
    rdChk("ctrl_after_unmapped", BASE + 32'h800, 32'd1, 1);
    rdChk("wcount_after_unmapped", BASE + 32'h804, 32'(wcnt), 1);

`ifdef IMEM_READBACK_EN
    prev = datO;
    r0 = rdStb;
    weI = 1'b0; adrI = BASE + 32'h20; selI = 4'hF; cyc = 1'b1; stb = 1'b1;
    sawAck = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      sawAck = sawAck | ack;
    end
    chk("abort_noack", 32'(sawAck), 32'd0);
    chk("abort_dat", datO, prev);
    chk("abort_strobe", 32'(rdStb - r0), 32'd1);
    @(posedge clk); #1;
`endif
    d = $urandom;
    wrChk("post_abort_wr", BASE + 32'h30, 4'hF, d);
    refMem[12] = d;
    wcnt++;
    rdChk("post_abort_rd", BASE + 32'h30, RB ? d : 32'h0, RDLAT);

    wrChk("hold_clr", BASE + 32'h800, 4'hF, 32'h0);
    weI = 1'b0; adrI = BASE + 32'h30; selI = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    rstN = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_csb_web", 32'({csb, web}), 32'd3);
    chk("midrst_hold", 32'(hold), 32'd1);
    chk("midrst_dat", datO, 32'd0);
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_din", din, 32'd0);
    chk("midrst_wmask", 32'(wmask), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    rdChk("wcount_after_rst", BASE + 32'h804, 32'd0, 1);
    rdChk("ctrl_after_rst", BASE + 32'h800, 32'd1, 1);
    rdChk("mem_kept", BASE + 32'h30, RB ? refMem[12] : 32'h0, RDLAT);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
